instr_fetch: RTL and testbench

//   Instruction fetch front end feeding the controlpath: holds the fetch PC, issues

---
 rtl/instr_fetch.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC plus single-outstanding word reader feeding a DEPTH-entry prefetch FIFO.
// Latency: ack in cycle M -> word on instruction in M+1; RUN with a free slot -> mem_req next cycle.
// Backpressure: issue pauses while the FIFO is full; optional stall counter built when FETCH_PERF_EN is defined.
module instr_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_inc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_fault,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        wait_instr,
  output logic        instr_segv,
  output logic [31:0] fetch_stalls
);

  localparam int unsigned   AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_squash, w_squash_nxt;
  // A misaligned redirect that lands while a request is outstanding must still
  // retire that request; this flag sends the squashed ack to HALT instead of RUN.
  logic          r_halt_pend, w_halt_pend_nxt;
  logic [31:0]   r_fpc, w_fpc_nxt;
  logic [31:0]   r_addr;

  logic          w_issue, w_push, w_pop, w_flush, w_outst;
  logic [31:0]   w_push_dat, w_push_pc;
  logic          w_push_flt;

  logic [31:0]   r_dat [DEPTH];
  logic [31:0]   r_pcs [DEPTH];
  logic          r_flt [DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_wr_idx;
  logic [CW-1:0] r_count;
  logic          w_empty;

  assign w_empty  = (r_count == '0);
  assign w_wr_idx = w_flush ? '0 : r_wr;

  // FSM state and fetch control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_squash    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_fpc       <= RESET_PC;
      r_addr      <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_squash    <= w_squash_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_fpc       <= w_fpc_nxt;
      if (w_issue) r_addr <= r_fpc;
    end
  end

  // Next-state, push/pop and redirect decisions; redirect overrides everything else
  always_comb begin
    w_state_nxt     = r_state;
    w_squash_nxt    = r_squash;
    w_halt_pend_nxt = r_halt_pend;
    w_fpc_nxt       = r_fpc;
    w_issue         = 1'b0;
    w_push          = 1'b0;
    w_push_dat      = 32'h0;
    w_push_pc       = r_fpc;
    w_push_flt      = 1'b0;
    w_flush         = 1'b0;
    w_outst         = 1'b0;
    w_pop           = pc_inc && !w_empty;

    if (redirect) begin
      w_flush      = 1'b1;
      w_pop        = 1'b0;
      w_fpc_nxt    = redirect_pc;
      w_outst      = (r_state == S_WAIT) && !mem_ack;
      w_squash_nxt = w_outst;
      if (redirect_pc[1:0] != 2'b00) begin
        w_push          = 1'b1;
        w_push_flt      = 1'b1;
        w_push_pc       = redirect_pc;
        w_halt_pend_nxt = w_outst;
        w_state_nxt     = w_outst ? S_WAIT : S_HALT;
      end else begin
        w_halt_pend_nxt = 1'b0;
        w_state_nxt     = w_outst ? S_WAIT : S_RUN;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_count < FULL) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (r_squash) begin
              w_squash_nxt    = 1'b0;
              w_halt_pend_nxt = 1'b0;
              w_state_nxt     = r_halt_pend ? S_HALT : S_RUN;
            end else if (mem_fault) begin
              w_push      = 1'b1;
              w_push_flt  = 1'b1;
              w_state_nxt = S_HALT;
            end else begin
              w_push      = 1'b1;
              w_push_dat  = mem_rdata;
              w_fpc_nxt   = r_fpc + 32'd4;
              w_state_nxt = S_RUN;
            end
          end
        end
        default: begin
          w_state_nxt = S_HALT;
        end
      endcase
    end
  end

  // Prefetch FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rd    <= '0;
      r_wr    <= w_push ? AW'(1) : '0;
      r_count <= w_push ? CW'(1) : '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Prefetch FIFO storage; contents are only observed through count-gated outputs
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dat[w_wr_idx] <= w_push_dat;
      r_pcs[w_wr_idx] <= w_push_pc;
      r_flt[w_wr_idx] <= w_push_flt;
    end
  end

  assign mem_req     = (r_state == S_WAIT);
  assign mem_addr    = r_addr;
  assign wait_instr  = w_empty;
  assign instruction = w_empty ? 32'h0 : r_dat[r_rd];
  assign instr_pc    = w_empty ? 32'h0 : r_pcs[r_rd];
  assign instr_segv  = !w_empty && r_flt[r_rd];

`ifdef FETCH_PERF_EN
  logic [31:0] r_stalls;

  // Count cycles with nothing to present while fetch is still live; saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stalls <= 32'h0;
    end else if (w_empty && (r_state != S_HALT) && (r_stalls != 32'hFFFF_FFFF)) begin
      r_stalls <= r_stalls + 32'd1;
    end
  end

  assign fetch_stalls = r_stalls;
`else
  assign fetch_stalls = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch fetch, fill, squash, fault, misalign and wrap behaviour.
// Latency: vectors driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: FIFO fill exercised by withholding pc_inc.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_inc = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_fault = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        wait_instr;
  logic        instr_segv;
  logic [31:0] fetch_stalls;

  int n_chk = 0;
  int n_fail = 0;

  instr_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_fault(mem_fault),
    .instruction(instruction), .instr_pc(instr_pc), .wait_instr(wait_instr),
    .instr_segv(instr_segv), .fetch_stalls(fetch_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_inc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wait;
    logic [31:0] e_ins;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic inc, input logic ack, input logic [31:0] d,
                              input logic req, input logic [31:0] addr, input logic w,
                              input logic [31:0] ins, input logic [31:0] ipc);
    vec_t v;
    v.pc_inc = inc; v.ack = ack; v.rdata = d;
    v.e_req = req; v.e_addr = addr; v.e_wait = w; v.e_ins = ins; v.e_ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic inc, input logic rd, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] dat, input logic flt);
    @(negedge clk);
    pc_inc = inc; redirect = rd; redirect_pc = rpc;
    mem_ack = ack; mem_rdata = dat; mem_fault = flt;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pc_inc = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; mem_fault = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst mem_req",      32'(mem_req), 32'h0);
    chk("rst mem_addr",     mem_addr, 32'h0);
    chk("rst instruction",  instruction, 32'h0);
    chk("rst instr_pc",     instr_pc, 32'h0);
    chk("rst wait_instr",   32'(wait_instr), 32'h1);
    chk("rst instr_segv",   32'(instr_segv), 32'h0);
    chk("rst fetch_stalls", fetch_stalls, 32'h0);
    rst_n = 1'b1;
  endtask

  vec_t tbl [16];

  initial begin
    logic [31:0] exp_stall;

    // Row k = k-th falling edge after reset release; outputs are for that cycle.
    tbl[0]  = mk(0, 1, 32'h11, 1, 32'h00, 1, 32'h00, 32'h0);
    tbl[1]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h11, 32'h0);
    tbl[2]  = mk(0, 1, 32'h22, 1, 32'h04, 0, 32'h11, 32'h0);
    tbl[3]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h11, 32'h0);
    tbl[4]  = mk(1, 1, 32'h33, 1, 32'h08, 0, 32'h11, 32'h0);
    tbl[5]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h22, 32'h4);
    tbl[6]  = mk(0, 1, 32'h44, 1, 32'h0C, 0, 32'h22, 32'h4);
    tbl[7]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h22, 32'h4);
    tbl[8]  = mk(0, 1, 32'h55, 1, 32'h10, 0, 32'h22, 32'h4);
    tbl[9]  = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h22, 32'h4);
    tbl[10] = mk(1, 0, 32'h00, 0, 32'h00, 0, 32'h22, 32'h4);
    tbl[11] = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h33, 32'h8);
    tbl[12] = mk(0, 0, 32'h00, 1, 32'h14, 0, 32'h33, 32'h8);
    tbl[13] = mk(1, 0, 32'h00, 1, 32'h14, 0, 32'h33, 32'h8);
    tbl[14] = mk(0, 1, 32'h66, 1, 32'h14, 0, 32'h44, 32'hC);
    tbl[15] = mk(0, 0, 32'h00, 0, 32'h00, 0, 32'h44, 32'hC);

    // Basic streaming, FIFO fill and refill
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].pc_inc, 1'b0, 32'h0, tbl[i].ack, tbl[i].rdata, 1'b0);
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d wait_instr", i), 32'(wait_instr), 32'(tbl[i].e_wait));
      chk($sformatf("row%0d instruction", i), instruction, tbl[i].e_ins);
      chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].e_ipc);
      chk($sformatf("row%0d instr_segv", i), 32'(instr_segv), 32'h0);
    end

    // Redirect while the request to 0x8 is outstanding; its late ack is discarded
    do_reset();
    step(0, 0, 0, 1, 32'h11, 0);
    idle();
    step(0, 0, 0, 1, 32'h22, 0);
    idle();
    step(0, 1, 32'h100, 0, 0, 0);
    chk("sq addr before redirect", mem_addr, 32'h8);
    idle();
    chk("sq req held", 32'(mem_req), 32'h1);
    chk("sq addr held", mem_addr, 32'h8);
    chk("sq flushed", 32'(wait_instr), 32'h1);
    step(0, 0, 0, 1, 32'hDEAD, 0);
    idle();
    chk("sq after ack wait", 32'(wait_instr), 32'h1);
    chk("sq after ack req", 32'(mem_req), 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("sq new req", 32'(mem_req), 32'h1);
    chk("sq new addr", mem_addr, 32'h100);
    step(0, 0, 0, 1, 32'h77, 0);
    chk("sq wait until ack", 32'(wait_instr), 32'h1);
    idle();
    chk("sq instruction", instruction, 32'h77);
    chk("sq instr_pc", instr_pc, 32'h100);

    // Fault at 0xC, drain earlier words, then redirect out of HALT
    do_reset();
    step(0, 0, 0, 1, 32'h11, 0);
    idle();
    step(0, 0, 0, 1, 32'h22, 0);
    idle();
    step(0, 0, 0, 1, 32'h33, 0);
    idle();
    step(0, 0, 0, 1, 32'hBAD, 1);
    chk("flt req addr", mem_addr, 32'hC);
    step(1, 0, 0, 0, 0, 0);
    chk("flt head0", instruction, 32'h11);
    step(1, 0, 0, 0, 0, 0);
    chk("flt head1", instruction, 32'h22);
    step(1, 0, 0, 0, 0, 0);
    chk("flt head2", instruction, 32'h33);
    idle();
    chk("flt segv", 32'(instr_segv), 32'h1);
    chk("flt instr_pc", instr_pc, 32'hC);
    chk("flt instruction", instruction, 32'h0);
    chk("flt wait", 32'(wait_instr), 32'h0);
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("flt halt req%0d", k), 32'(mem_req), 32'h0);
    end
    step(1, 0, 0, 0, 0, 0);
    idle();
    chk("flt popped wait", 32'(wait_instr), 32'h1);
    chk("flt popped req", 32'(mem_req), 32'h0);
    step(0, 1, 32'h40, 0, 0, 0);
    idle();
    idle();
    chk("flt redirect req", 32'(mem_req), 32'h1);
    chk("flt redirect addr", mem_addr, 32'h40);

    // Misaligned redirect coinciding with an ack: ack dropped, fault entry presented
    do_reset();
    step(0, 1, 32'h102, 1, 32'hAAAA, 0);
    idle();
    chk("mis segv", 32'(instr_segv), 32'h1);
    chk("mis instr_pc", instr_pc, 32'h102);
    chk("mis instruction", instruction, 32'h0);
    chk("mis wait", 32'(wait_instr), 32'h0);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk($sformatf("mis req%0d", k), 32'(mem_req), 32'h0);
    end

    // PC wrap after redirect to the top word
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle();
    chk("wrap flushed", 32'(wait_instr), 32'h1);
    step(0, 0, 0, 1, 32'h99, 0);
    chk("wrap addr0", mem_addr, 32'hFFFF_FFFC);
    idle();
    chk("wrap instruction", instruction, 32'h99);
    chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
    idle();
    chk("wrap req", 32'(mem_req), 32'h1);
    chk("wrap addr1", mem_addr, 32'h0);

    // Asynchronous reset drops the outstanding request immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst mem_req", 32'(mem_req), 32'h0);
    chk("arst wait", 32'(wait_instr), 32'h1);

    // Stall counter with first ack five cycles after reset release
`ifdef FETCH_PERF_EN
    exp_stall = 32'd6;
`else
    exp_stall = 32'd0;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) idle();
    step(0, 0, 0, 1, 32'h5A, 0);
    idle();
    chk("perf wait", 32'(wait_instr), 32'h0);
    chk("perf instruction", instruction, 32'h5A);
    chk("perf fetch_stalls", fetch_stalls, exp_stall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
